// File: rtl/video_mode_sequencer_pkg.sv
// rtl/video_mode_sequencer_pkg.sv - shared types, state codes and mode helpers for the video mode sequencer
package video_mode_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_480P = 2'd0,
    MODE_720P = 2'd1
  } mode_code_t;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE       = 3'd0;
  localparam seq_state_t ST_WAIT_FRAME = 3'd1;
  localparam seq_state_t ST_BLANK      = 3'd2;
  localparam seq_state_t ST_SWITCH     = 3'd3;
  localparam seq_state_t ST_SETTLE     = 3'd4;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_total;
    logic [11:0] v_active;
    logic [11:0] v_total;
    logic        hsync_pos;
    logic        vsync_pos;
  } video_mode_t;

  localparam video_mode_t VIDEO_MODE_480P = '{
    h_active: 12'd640, h_total: 12'd800, v_active: 12'd480, v_total: 12'd525,
    hsync_pos: 1'b0, vsync_pos: 1'b0
  };

  localparam video_mode_t VIDEO_MODE_720P = '{
    h_active: 12'd1280, h_total: 12'd1650, v_active: 12'd720, v_total: 12'd750,
    hsync_pos: 1'b1, vsync_pos: 1'b1
  };

  // Codes 2 and 3 are reserved and never reach mode_sel.
  function automatic logic code_is_valid(input logic [1:0] code);
    return (code == MODE_480P) || (code == MODE_720P);
  endfunction

  // Timing table lookup used by the video top level.
  function automatic video_mode_t mode_code_to_videomode(input logic [1:0] code);
    if (code == MODE_480P) begin
      return VIDEO_MODE_480P;
    end
    return VIDEO_MODE_720P;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_config_qualifier.sv
// rtl/video_mode_sequencer_config_qualifier.sv - debounces config_data and emits one event per stable value
module video_mode_sequencer_config_qualifier
  import video_mode_sequencer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] config_data_i,
  output logic       qual_valid_o,
  output logic [7:0] qual_data_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES);

  logic [7:0]    cfg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qual_valid_q, qual_valid_d;
  logic [7:0]    qual_data_q;
  logic          changed;

  // Only the force bit and the mode code matter; bits [6:2] never restart the count.
  always_comb begin
    changed = (config_data_i[7] != cfg_q[7]) || (config_data_i[1:0] != cfg_q[1:0]);
  end

  // Saturating stability counter; the event fires once, on the step into terminal.
  always_comb begin
    cnt_d        = cnt_q;
    qual_valid_d = 1'b0;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TERM) begin
      cnt_d        = cnt_q + CW'(1);
      qual_valid_d = (cnt_q == CNT_LAST);
    end
  end

  // Sample register, counter and registered event outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_q        <= 8'h00;
      cnt_q        <= '0;
      qual_valid_q <= 1'b0;
      qual_data_q  <= 8'h00;
    end else begin
      cfg_q        <= config_data_i;
      cnt_q        <= cnt_d;
      qual_valid_q <= qual_valid_d;
      if (qual_valid_d) begin
        qual_data_q <= cfg_q;
      end
    end
  end

  assign qual_valid_o = qual_valid_q;
  assign qual_data_o  = qual_data_q;

endmodule

// File: rtl/video_mode_sequencer.sv
// rtl/video_mode_sequencer.sv - frame-aligned runtime video mode switch with blanking and lag re-arm
module video_mode_sequencer
  import video_mode_sequencer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned BLANK_FRAMES  = 2,
  parameter int unsigned SETTLE_FRAMES = 4,
  parameter logic [1:0]  DEFAULT_MODE  = 2'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] config_data,
  input  logic       frame_start,
  output logic [1:0] mode_sel,
  output logic       mode_update,
  output logic       blank,
  output logic       lag_restart,
  output logic       busy,
  output logic       cfg_error
);

  localparam logic [7:0] BLANK_TERM  = (BLANK_FRAMES  > 255) ? 8'hFF : 8'(BLANK_FRAMES);
  localparam logic [7:0] SETTLE_TERM = (SETTLE_FRAMES > 255) ? 8'hFF : 8'(SETTLE_FRAMES);

  logic       qual_valid;
  logic [7:0] qual_data;
  logic       qual_unused;

  seq_state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] pending_q, pending_d;
  logic [7:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic       req_valid_q, req_valid_d;
  logic [2:0] req_data_q, req_data_d;
  logic       mode_update_q, mode_update_d;
  logic       blank_q, blank_d;
  logic       lag_restart_q, lag_restart_d;
  logic       busy_q, busy_d;
  logic       cfg_error_q, cfg_error_d;

  logic       ev_valid;
  logic       ev_force;
  logic [1:0] ev_code;

  video_mode_sequencer_config_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qualifier (
    .clock_i      (clock),
    .reset_i      (reset),
    .config_data_i(config_data),
    .qual_valid_o (qual_valid),
    .qual_data_o  (qual_data)
  );

  assign qual_unused = ^qual_data[6:2];

  // Event seen by IDLE: a fresh qualification wins over a request held during blanking.
  always_comb begin
    ev_valid = qual_valid | req_valid_q;
    ev_force = qual_valid ? qual_data[7]   : req_data_q[2];
    ev_code  = qual_valid ? qual_data[1:0] : req_data_q[1:0];
  end

  // Sequencer next state, frame counting and request holding.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    pending_d     = pending_q;
    frame_cnt_d   = frame_cnt_q;
    req_valid_d   = req_valid_q;
    req_data_d    = req_data_q;
    mode_update_d = 1'b0;
    lag_restart_d = 1'b0;
    cfg_error_d   = 1'b0;
    frame_cnt_inc = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        req_valid_d = 1'b0;
        if (ev_valid) begin
          if (!code_is_valid(ev_code)) begin
            cfg_error_d = 1'b1;
          end else if ((ev_code != mode_q) || ev_force) begin
            pending_d = ev_code;
            state_d   = ST_WAIT_FRAME;
          end
        end
      end
      ST_WAIT_FRAME: begin
        if (qual_valid && code_is_valid(qual_data[1:0])) begin
          pending_d = qual_data[1:0];
        end
        if (frame_start) begin
          frame_cnt_d = 8'd0;
          state_d     = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (frame_start) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == BLANK_TERM) begin
            mode_d        = pending_q;
            mode_update_d = 1'b1;
            state_d       = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        frame_cnt_d = 8'd0;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (frame_start) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == SETTLE_TERM) begin
            lag_restart_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q == ST_BLANK || state_q == ST_SWITCH || state_q == ST_SETTLE) && qual_valid) begin
      req_valid_d = 1'b1;
      req_data_d  = {qual_data[7], qual_data[1:0]};
    end

    blank_d = (state_d == ST_BLANK) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops everything at once without a lag_restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= DEFAULT_MODE;
      pending_q     <= DEFAULT_MODE;
      frame_cnt_q   <= 8'd0;
      req_valid_q   <= 1'b0;
      req_data_q    <= 3'd0;
      mode_update_q <= 1'b0;
      blank_q       <= 1'b0;
      lag_restart_q <= 1'b0;
      busy_q        <= 1'b0;
      cfg_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      req_valid_q   <= req_valid_d;
      req_data_q    <= req_data_d;
      mode_update_q <= mode_update_d;
      blank_q       <= blank_d;
      lag_restart_q <= lag_restart_d;
      busy_q        <= busy_d;
      cfg_error_q   <= cfg_error_d;
    end
  end

  assign mode_sel    = mode_q;
  assign mode_update = mode_update_q;
  assign blank       = blank_q;
  assign lag_restart = lag_restart_q;
  assign busy        = busy_q;
  assign cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// tb/tb_video_mode_sequencer.sv - directed and randomized checks of video_mode_sequencer against a reference model
module tb_video_mode_sequencer;

  localparam int STABLE = 4;
  localparam int BLANKF = 2;
  localparam int SETTLEF = 3;
  localparam logic [1:0] DEFMODE = 2'd1;
  localparam int FRAME_PERIOD = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] config_data = 8'h01;
  logic       frame_start = 1'b0;
  logic [1:0] mode_sel;
  logic       mode_update, blank, lag_restart, busy, cfg_error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int upd_cnt = 0, lag_cnt = 0, err_cnt = 0;
  bit busy_seen = 0;

  // Reference model: sequence phase with frames still to go, expected output values.
  localparam int P_IDLE = 0, P_WAIT = 1, P_BLANK = 2, P_SWITCH = 3, P_SETTLE = 4;
  int         m_phase, m_left, m_run;
  logic [2:0] m_prev_key;
  bit         m_ev, m_held;
  logic [7:0] m_ev_data, m_held_data;
  logic [1:0] m_mode, m_target;
  bit         e_upd, e_lag, e_err;

  video_mode_sequencer #(
    .STABLE_CYCLES(STABLE),
    .BLANK_FRAMES (BLANKF),
    .SETTLE_FRAMES(SETTLEF),
    .DEFAULT_MODE (DEFMODE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .config_data(config_data),
    .frame_start(frame_start),
    .mode_sel   (mode_sel),
    .mode_update(mode_update),
    .blank      (blank),
    .lag_restart(lag_restart),
    .busy       (busy),
    .cfg_error  (cfg_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_run = 1; m_prev_key = 3'd0;
    m_ev = 0; m_held = 0; m_ev_data = 8'h00; m_held_data = 8'h00;
    m_mode = DEFMODE; m_target = DEFMODE;
    e_upd = 0; e_lag = 0; e_err = 0;
  endtask

  // One clock of the model, from the inputs the DUT will sample at the coming edge.
  task automatic model_step();
    bit         ev;
    logic [7:0] evd;
    logic [2:0] key;
    ev = m_ev; evd = m_ev_data;
    e_upd = 0; e_lag = 0; e_err = 0;
    if (m_phase >= P_BLANK && ev) begin
      m_held = 1; m_held_data = evd;
    end
    case (m_phase)
      P_IDLE: begin
        if (!ev && m_held) begin ev = 1; evd = m_held_data; end
        m_held = 0;
        if (ev) begin
          if (evd[1:0] > 2'd1) e_err = 1;
          else if (evd[1:0] != m_mode || evd[7]) begin m_target = evd[1:0]; m_phase = P_WAIT; end
        end
      end
      P_WAIT: begin
        if (ev && evd[1:0] <= 2'd1) m_target = evd[1:0];
        if (frame_start) begin m_phase = P_BLANK; m_left = BLANKF; end
      end
      P_BLANK: if (frame_start) begin
        m_left--;
        if (m_left == 0) begin m_phase = P_SWITCH; m_mode = m_target; e_upd = 1; end
      end
      P_SWITCH: begin m_phase = P_SETTLE; m_left = SETTLEF; end
      default: if (frame_start) begin
        m_left--;
        if (m_left == 0) begin m_phase = P_IDLE; e_lag = 1; end
      end
    endcase
    key = {config_data[7], config_data[1:0]};
    if (key == m_prev_key) m_run = (m_run > STABLE + 1) ? m_run : m_run + 1;
    else m_run = 1;
    m_prev_key = key;
    m_ev = (m_run == STABLE + 1);
    m_ev_data = config_data;
  endtask

  task automatic check_outputs();
    chk("mode_sel", mode_sel, m_mode);
    chk("mode_update", mode_update, e_upd);
    chk("blank", blank, (m_phase >= P_BLANK));
    chk("lag_restart", lag_restart, e_lag);
    chk("busy", busy, (m_phase != P_IDLE));
    chk("cfg_error", cfg_error, e_err);
  endtask

  task automatic tick();
    frame_start = ((cyc % FRAME_PERIOD) == FRAME_PERIOD - 1);
    if (reset) model_reset(); else model_step();
    @(posedge clock);
    #1;
    cyc++;
    check_outputs();
    upd_cnt += int'(mode_update);
    lag_cnt += int'(lag_restart);
    err_cnt += int'(cfg_error);
    if (busy) busy_seen = 1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] cfg;
    model_reset();

    // 1. Reset values, then 8'h01 held: qualifies equal to mode_sel, nothing happens.
    ticks(3);
    chk("reset_mode_sel", mode_sel, 2'd1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_blank", blank, 1'b0);
    chk("reset_lag", lag_restart, 1'b0);
    reset = 1'b0;
    busy_seen = 0;
    ticks(300);
    chk("t1_busy_never", busy_seen, 1'b0);
    chk("t1_mode_sel", mode_sel, 2'd1);

    // 2. Switch to 480P.
    upd_cnt = 0; lag_cnt = 0;
    config_data = 8'h00;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    chk("t2_busy_latency", 8'(n), 8'd6);
    n = 0;
    while (busy && n < 1500) begin tick(); n++; end
    chk("t2_done_in_time", busy, 1'b0);
    chk("t2_mode_sel", mode_sel, 2'd0);
    chk("t2_updates", 8'(upd_cnt), 8'd1);
    chk("t2_lag_restarts", 8'(lag_cnt), 8'd1);

    // 3. Reserved code: one cfg_error, no sequence.
    err_cnt = 0; busy_seen = 0;
    config_data = 8'h02;
    ticks(200);
    chk("t3_errors", 8'(err_cnt), 8'd1);
    chk("t3_busy_never", busy_seen, 1'b0);
    chk("t3_mode_sel", mode_sel, 2'd0);

    // 4. Toggling faster than the qualifier window never qualifies.
    err_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      config_data = (i % 2 == 0) ? 8'h00 : 8'h01;
      ticks(3);
    end
    chk("t4_busy_never", busy_seen, 1'b0);
    chk("t4_errors", 8'(err_cnt), 8'd0);

    // 5. Second request during BLANK runs after the first completes.
    reset = 1'b1; config_data = 8'h01;
    ticks(2);
    reset = 1'b0;
    ticks(20);
    upd_cnt = 0;
    config_data = 8'h00;
    n = 0;
    while (!blank && n < 400) begin tick(); n++; end
    chk("t5_blank_reached", blank, 1'b1);
    config_data = 8'h01;
    n = 0;
    while (!(upd_cnt == 2 && !busy) && n < 3000) begin tick(); n++; end
    chk("t5_finished", busy, 1'b0);
    chk("t5_updates", 8'(upd_cnt), 8'd2);
    chk("t5_mode_sel", mode_sel, 2'd1);

    // 6. Reset in the middle of SETTLE.
    upd_cnt = 0; lag_cnt = 0;
    config_data = 8'h00;
    n = 0;
    while (upd_cnt == 0 && n < 1500) begin tick(); n++; end
    chk("t6_switched", 8'(upd_cnt), 8'd1);
    ticks(20);
    chk("t6_in_settle", blank, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_async_blank", blank, 1'b0);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_mode", mode_sel, 2'd1);
    chk("t6_async_lag", lag_restart, 1'b0);
    ticks(3);
    chk("t6_no_lag_pulse", 8'(lag_cnt), 8'd0);
    reset = 1'b0;

    // Randomized traffic with occasional mid-sequence resets.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      cfg = 8'($urandom_range(0, 255));
      cfg[1:0] = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      cfg[7] = ($urandom_range(0, 7) == 0);
      config_data = cfg;
      ticks($urandom_range(1, 250));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk("rand_async_busy", busy, 1'b0);
        ticks(2);
        reset = 1'b0;
      end
    end
    ticks(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
